cpld_bus_system: RTL and testbench
==================================

Name: cpld_bus_system

Overview:
CPLD top-level bridge between an AVR microcontroller, a 2M x 8 SRAM and the SNES cartridge bus.
- The AVR loads a 21-bit SRAM address serially, then steps it with a counter strobe.
- The AVR reads and writes SRAM bytes through a small bus FSM.
- A 7-bit command port can drive every AVR control line as an alternative to the dedicated pins.
- In SNES mode the SRAM is handed to the SNES bus.

Parameters:
ADDR_WIDTH, 21, SRAM/SNES address width
DATA_WIDTH, 8, data bus width
SREG_DIV, 2, avr_clk cycles per serial shift

Ports:
avr_clk  in  1  system clock, all logic on rising edge
avr_reset  in  1  synchronous active-high reset
sram_data  inout  8  SRAM data
sram_addr  out  21  SRAM address
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
sram_ce_n  out  1  SRAM chip enable, active low
snes_data  inout  8  SNES data bus
snes_addr  in  21  SNES address bus
avr_data  inout  8  AVR data bus
avr_ctrl  in  7  command code
avr_counter_n  in  1  address increment strobe, active low
avr_we_n  in  1  write request, active low
avr_oe_n  in  1  read request, active low
avr_si  in  1  serial address input
avr_sreg_en_n  in  1  shift enable, active low

Behaviour:
- Clocking and reset: one clock, avr_clk. Reset is synchronous and active-high: avr_reset, or the command-driven reset, sampled on the rising edge.
- Reset values:
  - address register 0
  - FSM in IDLE
  - sram_oe_n=1, sram_we_n=1, sram_ce_n=1
  - data buffer 0
  - all inout buses released (Z)
  - shift divider 0
- Effective control signals:
  - Each active-low control = pin AND its command latch (either side can assert it).
  - Effective si = pin OR latch.
  - Effective reset = avr_reset OR latch.
- Command decoder:
  - avr_ctrl is sampled every clock.
  - 0x01 is a no-op.
  - Set/clear pairs: 0x02/0x03 reset lo/hi; 0x04/0x05 sreg_en_n lo/hi; 0x06/0x07 si lo/hi; 0x08/0x09 oe_n lo/hi; 0x0A/0x0C we_n lo/hi; 0x0D/0x0E counter_n lo/hi; 0x0F/0x10 snes_mode lo/hi.
  - All other codes, including 0x00 and 0x0B, are no-ops.
  - Latch reset values: reset=0, sreg_en_n=1, si=0, oe_n=1, we_n=1, counter_n=1, snes_mode=0.
  - Only avr_reset clears the latches; the command-driven reset does not.
- Shift register:
  - While sreg_en_n=0, a divider fires once every SREG_DIV clocks.
  - On each fire: addr <= {addr[19:0], si}, MSB first.
  - 15 shifts from 0 of bits 100110011001111 give 0x004CCF.
  - Divider clears when sreg_en_n=1.
- Counter:
  - A falling edge of counter_n (registered previous value 1, current 0) increments addr by 1 on that clock.
  - Wraps from 0x1FFFFF to 0.
  - Shift has priority if both occur in the same clock.
- Bus FSM states: IDLE, RD_SETUP, RD_LATCH, RD_DRIVE, WR_LATCH, WR_STROBE, WR_HOLD.
- From IDLE:
  - oe_n=0 goes to RD_SETUP; else we_n=0 goes to WR_LATCH.
  - Read has priority when both are low.
- Read sequence:
  - RD_SETUP: ce_n=0, oe_n=0.
  - RD_LATCH: buffer <= sram_data.
  - RD_DRIVE: ce_n/oe_n still 0; then IDLE.
  - The cycle repeats while oe_n stays low, so new SRAM data appears at most 4 clocks later.
  - avr_data = buffer whenever effective oe_n=0 and at least one read has completed since the last reset; otherwise Z.
- Write sequence:
  - WR_LATCH: buffer <= avr_data, ce_n=0.
  - WR_STROBE: sram_data driven with buffer, we_n=0.
  - WR_HOLD: we_n=1, data still driven; then IDLE.
  - sram_data is Z in all other states.
- sram_ce_n=0 in every non-IDLE state; otherwise 1.
- SNES mode (latch=1):
  - FSM forced to IDLE.
  - sram_addr = snes_addr.
  - ce_n=0, oe_n=0, we_n=1.
  - snes_data driven with sram_data.
  - avr_data = Z.
  - Outside SNES mode, snes_data = Z.
- Reset mid-operation: aborts any read/write immediately and releases both buses.

Optional Feature:
- Macro AUTO_INC_EN.
  - Defined: address increments by 1 (with wrap) on exit from RD_DRIVE and from WR_HOLD, in addition to counter strobes. An FSM auto-increment and a counter strobe in the same clock increment by 1 only.
  - Undefined: address changes only via shift, counter or reset.

Test Plan:
- Reset, then sreg_en_n=0 and shift bits 100110011001111 at 2 clocks/bit -> sram_addr=0x004CCF.
- sreg_en_n=1, sram_data=0xAA, avr_oe_n=0 for 5 clocks -> sram_ce_n/sram_oe_n low in read states; avr_data=0xAA.
- Change sram_data to 0xBB with oe_n held low -> avr_data=0xBB within 4 clocks.
- oe_n=1, we_n=0, avr_data=0xEE -> one sram_we_n low pulse with sram_data=0xEE; sram_data Z afterwards.
- avr_counter_n low for 2 clocks then high -> sram_addr 0x004CCF->0x004CD0 (single increment); from 0x1FFFFF -> 0.
- avr_ctrl 0x03 then 0x02 -> datapath reset (addr=0, FSM IDLE); 0x04 then 0x07 -> shift of 1 with pins idle; 0x10 -> sram_addr follows snes_addr=0x123456.

Source files
------------

// File: rtl/cpld_bus_system_if.sv
// cpld_bus_system_if: AVR control pins, SNES address and SRAM control
// lines of the CPLD bridge; the three data buses stay plain inout ports.
interface cpld_bus_system_if #(
   parameter int ADDR_WIDTH = 21
) ();
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic                  sram_oe_n;
   logic                  sram_we_n;
   logic                  sram_ce_n;
   logic [ADDR_WIDTH-1:0] snes_addr;
   logic [6:0]            avr_ctrl;
   logic                  avr_counter_n;
   logic                  avr_we_n;
   logic                  avr_oe_n;
   logic                  avr_si;
   logic                  avr_sreg_en_n;

   modport master (
      output snes_addr, avr_ctrl, avr_counter_n,
      output avr_we_n, avr_oe_n, avr_si, avr_sreg_en_n,
      input  sram_addr, sram_oe_n, sram_we_n, sram_ce_n
   );

   modport slave (
      input  snes_addr, avr_ctrl, avr_counter_n,
      input  avr_we_n, avr_oe_n, avr_si, avr_sreg_en_n,
      output sram_addr, sram_oe_n, sram_we_n, sram_ce_n
   );
endinterface

// File: rtl/cpld_bus_system.sv
// cpld_bus_system: AVR <-> 2M x 8 SRAM bridge with SNES pass-through mode.
// Define AUTO_INC_EN to step the address after every SRAM read/write cycle.
module cpld_bus_system #(
   parameter int ADDR_WIDTH = 21,
   parameter int DATA_WIDTH = 8,
   parameter int SREG_DIV   = 2
) (
   input  logic                  avr_clk,
   input  logic                  avr_reset,
   cpld_bus_system_if.slave      bus,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   inout  wire  [DATA_WIDTH-1:0] snes_data,
   inout  wire  [DATA_WIDTH-1:0] avr_data
);
   localparam int DIV_W = (SREG_DIV > 1) ? $clog2(SREG_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SREG_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_LATCH, RD_DRIVE, WR_LATCH, WR_STROBE, WR_HOLD
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_c_rst, r_c_sreg_n, r_c_si, r_c_oe_n;
   logic                  r_c_we_n, r_c_cnt_n, r_snes;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [DIV_W-1:0]      r_div;
   logic                  r_cnt_prev, r_rd_done;
   logic                  w_rst, w_sreg_n, w_si, w_oe_n, w_we_n, w_cnt_n;
   logic                  w_fire, w_cnt_edge, w_auto;
   logic                  w_ce_n, w_oe_out_n, w_we_out_n, w_drv;

   // Pins and command latches are wired-AND (active low) / wired-OR.
   assign w_rst    = avr_reset | r_c_rst;
   assign w_sreg_n = bus.avr_sreg_en_n & r_c_sreg_n;
   assign w_si     = bus.avr_si | r_c_si;
   assign w_oe_n   = bus.avr_oe_n & r_c_oe_n;
   assign w_we_n   = bus.avr_we_n & r_c_we_n;
   assign w_cnt_n  = bus.avr_counter_n & r_c_cnt_n;

   always_ff @(posedge avr_clk) begin
      if (avr_reset) begin
         r_c_rst    <= 1'b0;
         r_c_sreg_n <= 1'b1;
         r_c_si     <= 1'b0;
         r_c_oe_n   <= 1'b1;
         r_c_we_n   <= 1'b1;
         r_c_cnt_n  <= 1'b1;
         r_snes     <= 1'b0;
      end else begin
         case (bus.avr_ctrl)
            7'h02: r_c_rst    <= 1'b0;
            7'h03: r_c_rst    <= 1'b1;
            7'h04: r_c_sreg_n <= 1'b0;
            7'h05: r_c_sreg_n <= 1'b1;
            7'h06: r_c_si     <= 1'b0;
            7'h07: r_c_si     <= 1'b1;
            7'h08: r_c_oe_n   <= 1'b0;
            7'h09: r_c_oe_n   <= 1'b1;
            7'h0A: r_c_we_n   <= 1'b0;
            7'h0C: r_c_we_n   <= 1'b1;
            7'h0D: r_c_cnt_n  <= 1'b0;
            7'h0E: r_c_cnt_n  <= 1'b1;
            7'h0F: r_snes     <= 1'b0;
            7'h10: r_snes     <= 1'b1;
            default: ;
         endcase
      end
   end

   assign w_fire     = !w_sreg_n && (r_div == DIV_LAST);
   assign w_cnt_edge = r_cnt_prev && !w_cnt_n;

`ifdef AUTO_INC_EN
   assign w_auto = (r_state == RD_DRIVE) || (r_state == WR_HOLD);
`else
   assign w_auto = 1'b0;
`endif

   always_ff @(posedge avr_clk) begin
      if (w_rst) begin
         r_addr     <= '0;
         r_buf      <= '0;
         r_div      <= '0;
         r_cnt_prev <= 1'b1;
         r_rd_done  <= 1'b0;
      end else begin
         r_cnt_prev <= w_cnt_n;
         if (w_sreg_n || w_fire)
            r_div <= '0;
         else
            r_div <= r_div + DIV_W'(1);
         // Shift wins; strobe and auto-increment merge into one step.
         if (w_fire)
            r_addr <= {r_addr[ADDR_WIDTH-2:0], w_si};
         else if (w_cnt_edge || w_auto)
            r_addr <= r_addr + ADDR_WIDTH'(1);
         if (r_state == RD_LATCH) begin
            r_buf     <= sram_data;
            r_rd_done <= 1'b1;
         end else if (r_state == WR_LATCH) begin
            r_buf <= avr_data;
         end
      end
   end

   always_ff @(posedge avr_clk) begin
      if (w_rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_ce_n     = 1'b1;
      w_oe_out_n = 1'b1;
      w_we_out_n = 1'b1;
      w_drv      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_oe_n)
               w_next = RD_SETUP;
            else if (!w_we_n)
               w_next = WR_LATCH;
         end
         RD_SETUP: begin
            w_ce_n     = 1'b0;
            w_oe_out_n = 1'b0;
            w_next     = RD_LATCH;
         end
         RD_LATCH: begin
            w_ce_n     = 1'b0;
            w_oe_out_n = 1'b0;
            w_next     = RD_DRIVE;
         end
         RD_DRIVE: begin
            w_ce_n     = 1'b0;
            w_oe_out_n = 1'b0;
            w_next     = IDLE;
         end
         WR_LATCH: begin
            w_ce_n = 1'b0;
            w_next = WR_STROBE;
         end
         WR_STROBE: begin
            w_ce_n     = 1'b0;
            w_we_out_n = 1'b0;
            w_drv      = 1'b1;
            w_next     = WR_HOLD;
         end
         WR_HOLD: begin
            w_ce_n = 1'b0;
            w_drv  = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (r_snes) begin
         w_next     = IDLE;
         w_ce_n     = 1'b0;
         w_oe_out_n = 1'b0;
         w_we_out_n = 1'b1;
         w_drv      = 1'b0;
      end
      // Reset aborts the cycle in progress on the same clock.
      if (w_rst) begin
         w_ce_n     = 1'b1;
         w_oe_out_n = 1'b1;
         w_we_out_n = 1'b1;
         w_drv      = 1'b0;
      end
   end

   assign bus.sram_addr = r_snes ? bus.snes_addr : r_addr;
   assign bus.sram_ce_n = w_ce_n;
   assign bus.sram_oe_n = w_oe_out_n;
   assign bus.sram_we_n = w_we_out_n;

   assign sram_data = w_drv ? r_buf : {DATA_WIDTH{1'bz}};
   assign snes_data = (r_snes && !w_rst) ? sram_data
                                         : {DATA_WIDTH{1'bz}};
   assign avr_data  = (!w_oe_n && r_rd_done && !r_snes && !w_rst)
                      ? r_buf : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_cpld_bus_system.sv
// tb_cpld_bus_system: random + directed stimulus, SRAM model and a
// scoreboard monitor checking address, read data and write strobes.
`timescale 1ns/1ps
module tb_cpld_bus_system;
   localparam int AW = 21;
   localparam int DW = 8;
   localparam int AMASK = 32'h1FFFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpld_bus_system_if #(.ADDR_WIDTH(AW)) bus ();
   wire [DW-1:0] sram_data;
   wire [DW-1:0] snes_data;
   wire [DW-1:0] avr_data;

   logic          sram_en;
   logic [DW-1:0] sram_val;
   logic          sprb_en;
   logic [DW-1:0] sprb_val;
   logic          avr_en;
   logic [DW-1:0] avr_val;
   logic          snes_en;
   logic [DW-1:0] snes_val;

   assign sram_data = sram_en ? sram_val
                    : (sprb_en ? sprb_val : 8'hzz);
   assign avr_data  = avr_en ? avr_val : 8'hzz;
   assign snes_data = snes_en ? snes_val : 8'hzz;

   cpld_bus_system #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .SREG_DIV(2)
   ) dut (
      .avr_clk(clk),
      .avr_reset(rst),
      .bus(bus.slave),
      .sram_data(sram_data),
      .snes_data(snes_data),
      .avr_data(avr_data)
   );

   // SRAM contents: preloaded pattern, overwritten by bus writes.
   logic [DW-1:0] sram_mem [int];
   logic [DW-1:0] ref_mem [int];
   int            ref_addr;

   function automatic logic [DW-1:0] init_val(input int a);
      return 8'(a * 7 + 3) ^ 8'(a >> 9);
   endfunction

   function automatic logic [DW-1:0] sram_rd(input int a);
      if (sram_mem.exists(a)) return sram_mem[a];
      return init_val(a);
   endfunction

   function automatic logic [DW-1:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   always @(negedge clk) begin
      sram_en  <= !bus.sram_ce_n && !bus.sram_oe_n;
      sram_val <= sram_rd(int'(bus.sram_addr));
      if (!bus.sram_ce_n && !bus.sram_we_n)
         sram_mem[int'(bus.sram_addr)] = sram_data;
   end

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } chk_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   chk_t chk_q[$];
   wr_t  wr_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic prev_we = 1'b1;

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         0: return 32'(bus.sram_addr);
         1: return 32'(avr_data);
         2: return 32'(snes_data);
         3: return {29'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n};
         default: return 32'(sram_data);
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t        c;
      wr_t         w;
      logic [31:0] act;
      if (!rst && prev_we && !bus.sram_we_n) begin
         n_chk++;
         if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected addr=%h data=%h",
                     bus.sram_addr, sram_data);
         end else begin
            w = wr_q.pop_front();
            if (bus.sram_addr !== w.addr || sram_data !== w.data ||
                bus.sram_ce_n !== 1'b0) begin
               n_fail++;
               $display("FAIL wr_strobe got addr=%h data=%h ce_n=%b exp addr=%h data=%h ce_n=0",
                        bus.sram_addr, sram_data, bus.sram_ce_n,
                        w.addr, w.data);
            end
         end
      end
      prev_we = bus.sram_we_n;
      while (chk_q.size() > 0) begin
         c   = chk_q.pop_front();
         act = observe(c.kind);
         n_chk++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", c.name, act, c.exp);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic want(input string nm, input int kind,
                       input logic [31:0] exp);
      chk_q.push_back('{nm, kind, exp});
   endtask

   task automatic load_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bus.avr_sreg_en_n = 1'b0;
         bus.avr_si        = v[i];
         tick(2);
      end
      bus.avr_sreg_en_n = 1'b1;
      bus.avr_si        = 1'b0;
      ref_addr = ((ref_addr << n) | int'(v)) & AMASK;
   endtask

   task automatic cnt_pulse(input bit via_cmd, input int low);
      if (via_cmd) begin
         bus.avr_ctrl = 7'h0D;
         tick(1);
         bus.avr_ctrl = 7'h01;
         tick(low);
         bus.avr_ctrl = 7'h0E;
         tick(1);
         bus.avr_ctrl = 7'h01;
         tick(1);
      end else begin
         bus.avr_counter_n = 1'b0;
         tick(low);
         bus.avr_counter_n = 1'b1;
         tick(1);
      end
      ref_addr = (ref_addr + 1) & AMASK;
   endtask

   task automatic do_write(input logic [DW-1:0] d, input bit via_cmd);
      avr_en  = 1'b1;
      avr_val = d;
      wr_q.push_back('{AW'(ref_addr), d});
      ref_mem[ref_addr] = d;
      if (via_cmd) begin
         bus.avr_ctrl = 7'h0A;
         tick(1);
         bus.avr_ctrl = 7'h0C;
         tick(1);
         bus.avr_ctrl = 7'h01;
      end else begin
         bus.avr_we_n = 1'b0;
         tick(1);
         bus.avr_we_n = 1'b1;
      end
      tick(4);
      avr_en = 1'b0;
   endtask

   task automatic do_read(input bit via_cmd, input string nm);
      if (via_cmd) begin
         bus.avr_ctrl = 7'h08;
         tick(1);
         bus.avr_ctrl = 7'h01;
      end else begin
         bus.avr_oe_n = 1'b0;
      end
      tick(6);
      want(nm, 1, 32'(ref_rd(ref_addr)));
      want({nm, "_ctl"}, 3, 32'h1);
      tick(1);
      if (via_cmd) begin
         bus.avr_ctrl = 7'h09;
         tick(1);
         bus.avr_ctrl = 7'h01;
      end else begin
         bus.avr_oe_n = 1'b1;
      end
      tick(4);
   endtask

   // A released bus reads back the bench's probe value unaltered.
   task automatic probe_z(input string nm, input bit s, input bit a,
                          input bit n);
      sprb_en  = s;
      sprb_val = 8'h11;
      avr_en   = a;
      avr_val  = 8'h22;
      snes_en  = n;
      snes_val = 8'h44;
      if (s) want({nm, "_sram_z"}, 4, 32'h11);
      if (a) want({nm, "_avr_z"}, 1, 32'h22);
      if (n) want({nm, "_snes_z"}, 2, 32'h44);
      tick(1);
      sprb_en = 1'b0;
      avr_en  = 1'b0;
      snes_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int            op;
      logic [31:0]   v;
      logic [DW-1:0] d;
      rst               = 1'b1;
      bus.avr_ctrl      = 7'h00;
      bus.avr_counter_n = 1'b1;
      bus.avr_we_n      = 1'b1;
      bus.avr_oe_n      = 1'b1;
      bus.avr_si        = 1'b0;
      bus.avr_sreg_en_n = 1'b1;
      bus.snes_addr     = '0;
      sprb_en           = 1'b0;
      sprb_val          = '0;
      avr_en            = 1'b0;
      avr_val           = '0;
      snes_en           = 1'b0;
      snes_val          = '0;
      ref_addr          = 0;
      tick(3);
      want("rst_addr", 0, 32'h0);
      want("rst_ctl", 3, 32'h7);
      probe_z("rst", 1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      bus.avr_ctrl = 7'h01;
      tick(1);

      load_bits(32'b100110011001111, 15);
      want("shift15", 0, 32'h004CCF);
      tick(1);

      sram_mem[32'h4CCF] = 8'hAA;
      ref_mem[32'h4CCF]  = 8'hAA;
      bus.avr_oe_n = 1'b0;
      tick(6);
      want("rd_aa", 1, 32'hAA);
      want("rd_ctl", 3, 32'h1);
      tick(1);
      sram_mem[32'h4CCF] = 8'hBB;
      ref_mem[32'h4CCF]  = 8'hBB;
      tick(4);
      want("rd_bb", 1, 32'hBB);
      tick(1);
      bus.avr_oe_n = 1'b1;
      tick(4);
      probe_z("rd_end", 1'b1, 1'b1, 1'b0);

      do_write(8'hEE, 1'b0);
      probe_z("wr_end", 1'b1, 1'b0, 1'b0);
      want("wr_ctl", 3, 32'h7);
      tick(1);
      do_read(1'b1, "rd_ee");

      cnt_pulse(1'b0, 2);
      want("cnt_inc", 0, 32'h004CD0);
      tick(1);
      load_bits(32'h1FFFFF, 21);
      want("addr_max", 0, 32'h1FFFFF);
      tick(1);
      cnt_pulse(1'b1, 1);
      want("cnt_wrap", 0, 32'h0);
      tick(1);

      load_bits(32'h0A5A5A, 21);
      want("pre_cmdrst", 0, 32'h0A5A5A);
      tick(1);
      bus.avr_ctrl = 7'h03;
      tick(1);
      bus.avr_ctrl = 7'h02;
      tick(1);
      bus.avr_ctrl = 7'h01;
      ref_addr = 0;
      want("cmdrst_addr", 0, 32'h0);
      want("cmdrst_ctl", 3, 32'h7);
      tick(1);

      bus.avr_ctrl = 7'h04;
      tick(1);
      bus.avr_ctrl = 7'h07;
      tick(1);
      bus.avr_ctrl = 7'h05;
      tick(1);
      bus.avr_ctrl = 7'h06;
      tick(1);
      bus.avr_ctrl = 7'h01;
      ref_addr = ((ref_addr << 1) | 1) & AMASK;
      tick(2);
      want("cmd_shift", 0, 32'(ref_addr));
      tick(1);
      do_read(1'b0, "rd_a1");

      bus.snes_addr = 21'h123456;
      bus.avr_ctrl  = 7'h10;
      tick(1);
      bus.avr_ctrl = 7'h01;
      bus.avr_oe_n = 1'b0;
      tick(2);
      want("snes_addr", 0, 32'h123456);
      want("snes_ctl", 3, 32'h1);
      want("snes_data", 2, 32'(ref_rd(32'h123456)));
      tick(1);
      probe_z("snes", 1'b0, 1'b1, 1'b0);
      bus.avr_oe_n = 1'b1;
      bus.avr_ctrl = 7'h0F;
      tick(1);
      bus.avr_ctrl = 7'h01;
      tick(2);
      want("unsnes_addr", 0, 32'(ref_addr));
      want("unsnes_ctl", 3, 32'h7);
      probe_z("unsnes", 1'b1, 1'b1, 1'b1);

      for (int i = 0; i < 24; i++) begin
         op = int'($urandom_range(0, 3));
         case (op)
            0: begin
               v = 32'($urandom) & AMASK;
               load_bits(v, 21);
               want("rnd_load", 0, 32'(ref_addr));
               tick(1);
            end
            1: begin
               cnt_pulse(1'($urandom), int'($urandom_range(1, 3)));
               want("rnd_cnt", 0, 32'(ref_addr));
               tick(1);
            end
            2: begin
               d = 8'($urandom);
               do_write(d, 1'($urandom));
               do_read(1'($urandom), "rnd_rdback");
            end
            default: do_read(1'($urandom), "rnd_rd");
         endcase
      end

      tick(5);
      n_chk++;
      if (wr_q.size() != 0 || chk_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending_writes=%0d pending_checks=%0d exp=0",
                  wr_q.size(), chk_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
